multi_channel_timestamp: RTL and testbench

//  Multichannel successor to the single-channel detect timer. A free-running
//  TW-bit counter is shared by NCH channels. Each rising edge of detect[i] is

---
 rtl/multi_channel_timestamp.sv | 127 ++++++++++++
 tb/tb_multi_channel_timestamp.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_timestamp.sv
// Multichannel detect timestamper: a shared free-running counter stamps rising edges on
// each channel; stamps leave through one round-robin arbitrated valid/ack port.
module multi_channel_timestamp #(
  parameter int NCH = 4,
  parameter int TW  = 32,
  parameter int CW  = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] detect,
  input  logic [NCH-1:0] ch_enable,
  output logic [TW-1:0]  ts_data,
  output logic [CW-1:0]  ts_ch,
  output logic           ts_valid,
  input  logic           ts_ack,
  output logic [NCH-1:0] ovf,
  input  logic           ovf_clr,
  output logic [TW-1:0]  timer_now
);

  logic [TW-1:0]  timer;
  logic [NCH-1:0] det_q;
  logic [NCH-1:0] edge_det;
  logic [NCH-1:0] pending;
  logic [NCH-1:0] eligible;
  logic [NCH-1:0] xfer;
  logic [NCH-1:0] ovf_set;
  logic [TW-1:0]  cap [NCH];
  logic [CW-1:0]  rr_ptr;
  logic [CW-1:0]  grant;
  logic           grant_valid;
  logic           slot_free;

  assign timer_now = timer;

  // det_q resets high so a detect already asserted through reset never counts as an edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      timer <= '0;
      det_q <= '1;
    end else begin
      timer <= timer + 1'b1;
      det_q <= detect;
    end
  end

  always_comb begin
    edge_det  = detect & ~det_q;
    eligible  = pending & ch_enable;
    slot_free = ~ts_valid | ts_ack;
  end

  // Round-robin search starts just after the last granted channel
  always_comb begin
    int idx;
    idx         = 0;
    grant       = '0;
    grant_valid = 1'b0;
    for (int k = 1; k <= NCH; k++) begin
      idx = (int'(rr_ptr) + k) % NCH;
      if (!grant_valid && eligible[idx]) begin
        grant       = CW'(idx);
        grant_valid = 1'b1;
      end
    end
  end

  always_comb begin
    xfer = '0;
    if (slot_free && grant_valid) begin
      xfer[grant] = 1'b1;
    end
    ovf_set = edge_det & ch_enable & pending & ~xfer;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ts_valid <= 1'b0;
      ts_data  <= '0;
      ts_ch    <= '0;
      rr_ptr   <= CW'(NCH - 1);
    end else if (slot_free) begin
      if (grant_valid) begin
        ts_valid <= 1'b1;
        ts_data  <= cap[grant];
        ts_ch    <= grant;
        rr_ptr   <= grant;
      end else begin
        ts_valid <= 1'b0;
      end
    end
  end

  // A slot being transferred this cycle can accept a new edge in the same cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      pending <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (!ch_enable[i]) begin
          pending[i] <= 1'b0;
        end else if (edge_det[i] && (!pending[i] || xfer[i])) begin
          pending[i] <= 1'b1;
        end else if (xfer[i]) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (edge_det[i] && ch_enable[i] && (!pending[i] || xfer[i])) begin
        cap[i] <= timer;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ovf <= '0;
    end else begin
      ovf <= ovf_set | (ovf & ~{NCH{ovf_clr}});
    end
  end

endmodule

// File: tb/tb_multi_channel_timestamp.sv
// Directed bench for multi_channel_timestamp (TW=8 so the counter wrap is reachable);
// a scoreboard queue holds expected stamps and a monitor checks every accepted output.
module tb_multi_channel_timestamp;

  localparam int NCH = 4;
  localparam int TW  = 8;
  localparam int CW  = 2;

  typedef struct {
    logic [CW-1:0] ch;
    logic [TW-1:0] data;
  } exp_t;

  logic           clk;
  logic           rst;
  logic [NCH-1:0] detect;
  logic [NCH-1:0] ch_enable;
  logic [TW-1:0]  ts_data;
  logic [CW-1:0]  ts_ch;
  logic           ts_valid;
  logic           ts_ack;
  logic [NCH-1:0] ovf;
  logic           ovf_clr;
  logic [TW-1:0]  timer_now;

  logic [TW-1:0]  model_timer;
  exp_t           sb [$];
  int             compared;
  int             mismatched;

  multi_channel_timestamp #(.NCH(NCH), .TW(TW), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .detect    (detect),
    .ch_enable (ch_enable),
    .ts_data   (ts_data),
    .ts_ch     (ts_ch),
    .ts_valid  (ts_valid),
    .ts_ack    (ts_ack),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr),
    .timer_now (timer_now)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle reference used only to schedule stimulus at given counter values
  always @(posedge clk) model_timer <= rst ? model_timer + 8'd1 : 8'd0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [NCH-1:0] det, input logic [NCH-1:0] en,
                               input logic ack, input logic clr);
    detect    = det;
    ch_enable = en;
    ts_ack    = ack;
    ovf_clr   = clr;
  endtask

  task automatic push_exp(input logic [CW-1:0] ch, input logic [TW-1:0] data);
    exp_t e;
    e.ch   = ch;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic wait_timer(input logic [TW-1:0] v);
    bit found;
    found = 1'b0;
    for (int c = 0; c < 600 && !found; c++) begin
      @(posedge clk);
      #1;
      if (model_timer == v) found = 1'b1;
    end
    if (!found) checkOutput("wait_timer_timeout", 32'd1, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sb.delete();
    rst = 1'b1;
  endtask

  // Monitor: every accepted output must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst && ts_valid && ts_ack) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_output_ch", 32'(ts_ch), 32'hFFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("sb_ch", 32'(ts_ch), 32'(e.ch));
        checkOutput("sb_data", 32'(ts_data), 32'(e.data));
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    compared   = 0;
    mismatched = 0;
    applyStimulus(4'b0001, 4'b1111, 1'b1, 1'b0);
    do_reset();

    // Detect held through reset must not trigger; counter starts at 0
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checkOutput("t1_timer", 32'(timer_now), 32'(k));
      checkOutput("t1_valid", 32'(ts_valid), 32'd0);
      checkOutput("t1_ovf", 32'(ovf), 32'd0);
      @(posedge clk);
      #1;
    end
    applyStimulus(4'b0000, 4'b1111, 1'b1, 1'b0);

    // Simultaneous edges at timer 7 leave in order 0,1,2,3 after reset
    do_reset();
    wait_timer(8'd7);
    applyStimulus(4'b1111, 4'b1111, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) push_exp(CW'(k), 8'd7);
    wait_timer(8'd9);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("t3_valid", 32'(ts_valid), 32'd1);
      checkOutput("t3_ch", 32'(ts_ch), 32'(k));
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    checkOutput("t3_idle", 32'(ts_valid), 32'd0);
    applyStimulus(4'b0000, 4'b1111, 1'b1, 1'b0);

    // Channel 2 edge at 100, 50-cycle pulse gives one stamp two cycles later
    wait_timer(8'd100);
    applyStimulus(4'b0100, 4'b1111, 1'b1, 1'b0);
    push_exp(2'd2, 8'd100);
    wait_timer(8'd101);
    @(negedge clk);
    checkOutput("t2_valid_early", 32'(ts_valid), 32'd0);
    wait_timer(8'd102);
    @(negedge clk);
    checkOutput("t2_valid", 32'(ts_valid), 32'd1);
    checkOutput("t2_ch", 32'(ts_ch), 32'd2);
    checkOutput("t2_data", 32'(ts_data), 32'd100);
    wait_timer(8'd150);
    applyStimulus(4'b0000, 4'b1111, 1'b1, 1'b0);
    wait_timer(8'd155);
    @(negedge clk);
    checkOutput("t2_single", 32'(ts_valid), 32'd0);

    // Held output, second edge queued, third edge overflows
    applyStimulus(4'b0000, 4'b1111, 1'b0, 1'b0);
    wait_timer(8'd10);
    applyStimulus(4'b0010, 4'b1111, 1'b0, 1'b0);
    push_exp(2'd1, 8'd10);
    wait_timer(8'd12);
    applyStimulus(4'b0000, 4'b1111, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("t4_valid", 32'(ts_valid), 32'd1);
    checkOutput("t4_data_first", 32'(ts_data), 32'd10);
    wait_timer(8'd20);
    applyStimulus(4'b0010, 4'b1111, 1'b0, 1'b0);
    push_exp(2'd1, 8'd20);
    wait_timer(8'd22);
    applyStimulus(4'b0000, 4'b1111, 1'b0, 1'b0);
    wait_timer(8'd30);
    applyStimulus(4'b0010, 4'b1111, 1'b0, 1'b0);
    wait_timer(8'd32);
    applyStimulus(4'b0000, 4'b1111, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("t4_ovf_set", 32'(ovf), 32'b0010);
    checkOutput("t4_data_stable", 32'(ts_data), 32'd10);
    checkOutput("t4_ch_stable", 32'(ts_ch), 32'd1);
    wait_timer(8'd33);
    applyStimulus(4'b0000, 4'b1111, 1'b1, 1'b0);
    wait_timer(8'd36);
    @(negedge clk);
    checkOutput("t4_drained", 32'(ts_valid), 32'd0);
    checkOutput("t4_ovf_sticky", 32'(ovf), 32'b0010);
    wait_timer(8'd37);
    applyStimulus(4'b0000, 4'b1111, 1'b1, 1'b1);
    wait_timer(8'd38);
    applyStimulus(4'b0000, 4'b1111, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("t4_ovf_clr", 32'(ovf), 32'd0);

    // Counter wrap: stamps 255 then 0
    wait_timer(8'd255);
    applyStimulus(4'b0001, 4'b1111, 1'b1, 1'b0);
    push_exp(2'd0, 8'd255);
    wait_timer(8'd0);
    applyStimulus(4'b0010, 4'b1111, 1'b1, 1'b0);
    push_exp(2'd1, 8'd0);
    wait_timer(8'd1);
    @(negedge clk);
    checkOutput("t5_first_data", 32'(ts_data), 32'd255);
    wait_timer(8'd2);
    @(negedge clk);
    checkOutput("t5_second_data", 32'(ts_data), 32'd0);
    checkOutput("t5_second_ch", 32'(ts_ch), 32'd1);
    wait_timer(8'd4);
    applyStimulus(4'b0000, 4'b1111, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("t5_idle", 32'(ts_valid), 32'd0);

    // Disabling a channel discards its queued stamp
    applyStimulus(4'b0000, 4'b1111, 1'b0, 1'b0);
    wait_timer(8'd40);
    applyStimulus(4'b0100, 4'b1111, 1'b0, 1'b0);
    push_exp(2'd2, 8'd40);
    wait_timer(8'd42);
    applyStimulus(4'b0000, 4'b1111, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("t6_valid", 32'(ts_valid), 32'd1);
    wait_timer(8'd45);
    applyStimulus(4'b1000, 4'b1111, 1'b0, 1'b0);
    wait_timer(8'd46);
    applyStimulus(4'b0000, 4'b1111, 1'b0, 1'b0);
    wait_timer(8'd48);
    applyStimulus(4'b0000, 4'b0111, 1'b0, 1'b0);
    wait_timer(8'd50);
    applyStimulus(4'b0000, 4'b1111, 1'b0, 1'b0);
    wait_timer(8'd52);
    applyStimulus(4'b0000, 4'b1111, 1'b1, 1'b0);
    wait_timer(8'd55);
    @(negedge clk);
    checkOutput("t6_discarded", 32'(ts_valid), 32'd0);
    checkOutput("t6_ovf", 32'(ovf), 32'd0);

    // Reset while an output is held and another channel is pending
    applyStimulus(4'b0000, 4'b1111, 1'b0, 1'b0);
    wait_timer(8'd60);
    applyStimulus(4'b0001, 4'b1111, 1'b0, 1'b0);
    push_exp(2'd0, 8'd60);
    wait_timer(8'd62);
    applyStimulus(4'b0000, 4'b1111, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("t6_held", 32'(ts_valid), 32'd1);
    wait_timer(8'd63);
    applyStimulus(4'b0010, 4'b1111, 1'b0, 1'b0);
    wait_timer(8'd65);
    applyStimulus(4'b0000, 4'b1111, 1'b0, 1'b0);
    do_reset();
    @(negedge clk);
    checkOutput("t6_rst_valid", 32'(ts_valid), 32'd0);
    checkOutput("t6_rst_data", 32'(ts_data), 32'd0);
    checkOutput("t6_rst_ch", 32'(ts_ch), 32'd0);
    checkOutput("t6_rst_timer", 32'(timer_now), 32'd0);
    applyStimulus(4'b0000, 4'b1111, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("t6_rst_empty", 32'(ts_valid), 32'd0);
    end

    checkOutput("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
